uart_tx_serializer: RTL and testbench

- Transmit serializer for the UART: accepts a parallel byte via valid/ready and shifts it out LSB-first on tx_o.
- Frame: start bit, DATA_BITS data bits, optional parity, 1 or 2 stop bits.
- Sits directly downstream of the baud-rate generator.
  - Drives the generator's enable (baud_en_o).
  - Consumes its one-cycle bit-done pulse (bit_done_i) to advance one bit per pulse.

---
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Transmit serializer for the UART. Accepts a parallel word over a
//   valid/ready handshake and shifts it out LSB-first on tx_o as:
//   start bit, DATA_BITS data bits, optional parity bit, 1 or 2 stop bits.
//   It drives the enable of the baud-rate generator for the whole frame
//   and advances one line bit per bit_done_i pulse.
//
// Ports
//   clk_i       system clock, rising edge
//   rstn_i      asynchronous active-low reset
//   tx_data_i   word to transmit
//   tx_valid_i  tx_data_i valid
//   tx_ready_o  word can be accepted (state == IDLE), combinational
//   baud_en_o   baud generator enable, high for the whole frame
//   bit_done_i  one-cycle end-of-bit pulse from the baud generator
//   tx_o        serial line, idle high
//   tx_busy_o   frame in progress
//   tx_done_o   one-cycle pulse when the last stop bit completes
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 baud_en_o,
  input  logic                 bit_done_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  localparam int            IW        = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  // Value of the stop counter during the final stop bit.
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 parity;

  assign tx_ready_o = (state == S_IDLE);

  // tx_o always carries the bit of the current state, so each transition
  // loads the line value of the bit being entered. baud_en_o drops in the
  // IDLE cycle between frames, which restarts the generator from zero and
  // gives the next start bit a full period.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      parity    <= 1'b0;
      tx_o      <= 1'b1;
      baud_en_o <= 1'b0;
      tx_busy_o <= 1'b0;
      tx_done_o <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // bit_done_i is ignored here; the generator is disabled anyway.
          if (tx_valid_i) begin
            shreg     <= tx_data_i;
            parity    <= (^tx_data_i) ^ (PARITY_ODD != 0);
            state     <= S_START;
            tx_o      <= 1'b0;
            baud_en_o <= 1'b1;
            tx_busy_o <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done_i) begin
            state   <= S_DATA;
            tx_o    <= shreg[0];
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (bit_done_i) begin
            if (bit_idx != LAST_IDX) begin
              // shreg[0] is on the line; shreg[1] becomes the next bit.
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end else if (PARITY_EN != 0) begin
              state <= S_PARITY;
              tx_o  <= parity;
            end else begin
              state    <= S_STOP;
              tx_o     <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end
        end
        S_PARITY: begin
          if (bit_done_i) begin
            state    <= S_STOP;
            tx_o     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_done_i) begin
            if (stop_cnt == STOP_LAST) begin
              state     <= S_IDLE;
              baud_en_o <= 1'b0;
              tx_busy_o <= 1'b0;
              tx_done_o <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          tx_o      <= 1'b1;
          baud_en_o <= 1'b0;
          tx_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Four serializer configurations share one input stream:
//     u0 8N1, u1 8E1, u2 8O1, u3 8N2.
//   Each has its own baud generator model (cfg_div = 3, 4-clock bits).
//   Per-cycle observation vector: {tx, baud_en, busy, done, ready}.
module tb_uart_tx_serializer;

  localparam int CFG_DIV = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;

  wire [3:0] tx_w, en_w, busy_w, done_w, rdy_w, bd_w;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_baud
    int cnt;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                       cnt <= 0;
      else if (!en_w[g] || cnt == CFG_DIV) cnt <= 0;
      else                             cnt <= cnt + 1;
    end
    assign bd_w[g] = en_w[g] && (cnt == CFG_DIV);
  end

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy_w[0]), .baud_en_o(en_w[0]), .bit_done_i(bd_w[0]),
    .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_o(done_w[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy_w[1]), .baud_en_o(en_w[1]), .bit_done_i(bd_w[1]),
    .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_o(done_w[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy_w[2]), .baud_en_o(en_w[2]), .bit_done_i(bd_w[2]),
    .tx_o(tx_w[2]), .tx_busy_o(busy_w[2]), .tx_done_o(done_w[2]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk_i(clk), .rstn_i(rstn), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy_w[3]), .baud_en_o(en_w[3]), .bit_done_i(bd_w[3]),
    .tx_o(tx_w[3]), .tx_busy_o(busy_w[3]), .tx_done_o(done_w[3]));

  // Present a word for one accepting edge; returns 1 time unit after that
  // edge (cycle 0 of the frame, start bit on the line).
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      obs = {tx_w[k], en_w[k], busy_w[k], done_w[k], rdy_w[k]};
      nvec++;
      if (obs !== 5'b10001) begin
        nerr++;
        $display("FAIL reset_held u%0d got=%b exp=10001", k, obs);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      obs = {tx_w[k], en_w[k], busy_w[k], done_w[k], rdy_w[k]};
      nvec++;
      if (obs !== 5'b10001) begin
        nerr++;
        $display("FAIL reset_idle u%0d got=%b exp=10001", k, obs);
      end
    end
  endtask

  // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1. Junk on valid/data while busy.
  task automatic test_basic();
    logic [9:0] f;
    logic [4:0] obs, exp;
    f = 10'b11_0100_1010;
    send(8'hA5);
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 40)       exp = {f[c/4], 4'b1100};
      else if (c == 40) exp = 5'b10011;
      else              exp = 5'b10001;
      obs = {tx_w[0], en_w[0], busy_w[0], done_w[0], rdy_w[0]};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL basic_8n1 c=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c >= 4 && c <= 20) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
    end
    repeat (6) @(posedge clk);
  endtask

  // 0x07: even parity bit 1 (u1), odd parity bit 0 (u2); 11 bit periods.
  task automatic test_parity();
    logic [10:0] f1, f2, f;
    logic [4:0]  obs, exp;
    f1 = 11'b11_0000_0111_0;
    f2 = 11'b10_0000_0111_0;
    send(8'h07);
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      for (int k = 1; k <= 2; k++) begin
        f = (k == 1) ? f1 : f2;
        if (c < 44)       exp = {f[c/4], 4'b1100};
        else if (c == 44) exp = 5'b10011;
        else              exp = 5'b10001;
        obs = {tx_w[k], en_w[k], busy_w[k], done_w[k], rdy_w[k]};
        nvec++;
        if (obs !== exp) begin
          nerr++;
          $display("FAIL parity u%0d c=%0d got=%b exp=%b", k, c, obs, exp);
        end
      end
    end
    repeat (4) @(posedge clk);
  endtask

  // 8N2 0x00: start + 8 zeros + two stop bits; done only after the second.
  task automatic test_two_stop();
    logic [10:0] f;
    logic [4:0]  obs, exp;
    f = 11'b11_0000_0000_0;
    send(8'h00);
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 44)       exp = {f[c/4], 4'b1100};
      else if (c == 44) exp = 5'b10011;
      else              exp = 5'b10001;
      obs = {tx_w[3], en_w[3], busy_w[3], done_w[3], rdy_w[3]};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL two_stop c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  // Valid held: 0x55 then 0x3C. u0 accepts the second word one cycle
  // after its tx_done_o; the line never dips between frames.
  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    logic [4:0] obs, exp;
    f1 = 10'b10_1010_1010;
    f2 = 10'b10_0111_1000;
    send(8'h55);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    for (int c = 0; c <= 82; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 40)       exp = {f1[c/4], 4'b1100};
      else if (c == 40) exp = 5'b10011;
      else if (c < 81)  exp = {f2[(c-41)/4], 4'b1100};
      else if (c == 81) exp = 5'b10011;
      else              exp = 5'b10001;
      obs = {tx_w[0], en_w[0], busy_w[0], done_w[0], rdy_w[0]};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c == 41) tx_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  // Reset pulse during data bit 3 of a 0x00 frame, then 0x81 on u0.
  task automatic test_reset_mid_frame();
    logic [9:0] f;
    logic [4:0] obs, exp;
    f = 10'b11_0000_0010;
    send(8'h00);
    repeat (17) @(posedge clk);
    #1;
    nvec++;
    if (tx_w !== 4'h0) begin
      nerr++;
      $display("FAIL mid_frame_line got=%b exp=0000", tx_w);
    end
    #2;
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      obs = {tx_w[k], en_w[k], busy_w[k], done_w[k], rdy_w[k]};
      nvec++;
      if (obs !== 5'b10001) begin
        nerr++;
        $display("FAIL async_abort u%0d got=%b exp=10001", k, obs);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      nvec++;
      if ({tx_w, done_w, en_w} !== 12'hF00) begin
        nerr++;
        $display("FAIL after_abort c=%0d got tx=%b done=%b en=%b exp tx=1111 done=0000 en=0000",
                 c, tx_w, done_w, en_w);
      end
    end
    send(8'h81);
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 40)       exp = {f[c/4], 4'b1100};
      else if (c == 40) exp = 5'b10011;
      else              exp = 5'b10001;
      obs = {tx_w[0], en_w[0], busy_w[0], done_w[0], rdy_w[0]};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL post_reset_0x81 c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    repeat (6) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
